// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the parametrised 1-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {LOAD_W, LOAD_X, COMPUTE} state_t;

  localparam int SAT_W = 128;

  // Accumulator never overflows: M products of T x T signed operands.
  function automatic int acc_width(input int t, input int m);
    return 2 * t + $clog2(m);
  endfunction

  // Floor shift by frac, clamp to the signed t-bit range, optional ReLU.
  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac,
    input int                      t,
    input bit                      relu
  );
    logic signed [SAT_W-1:0] s, lo, hi;
    s  = acc >>> frac;
    lo = -(128'sd1 <<< (t - 1));
    hi = ~lo;
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    if (relu && s[SAT_W-1]) s = '0;
    return s;
  endfunction

endpackage

// File: rtl/conv_mac_lanes.sv
// P parallel signed multipliers summed into one registered accumulator.
module conv_mac_lanes #(
  parameter int T  = 16,
  parameter int P  = 1,
  parameter int AW = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [P-1:0][T-1:0]   x_lane,
  input  logic [P-1:0][T-1:0]   w_lane,
  output logic signed [AW-1:0]  acc_nxt
);

  logic signed [2*T-1:0] prod [P];
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  acc;

  for (genvar j = 0; j < P; j++) begin : g_lane
    assign prod[j] = $signed(x_lane[j]) * $signed(w_lane[j]);
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < P; j++) sum = sum + AW'(prod[j]);
  end

  // clr starts a fresh output without spending a cycle on clearing.
  assign acc_nxt = (clr ? '0 : acc) + sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   acc <= '0;
    else if (en) acc <= acc_nxt;
  end

endmodule

// File: rtl/conv_1d_param.sv
// Streaming 1-D convolution: load M weights, load N samples, emit N-M+1 saturated outputs.
module conv_1d_param
  import conv_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 10,
  parameter int T    = 16,
  parameter int P    = 1,
  parameter int FRAC = 0,
  parameter int RELU = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [T-1:0] w_data,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int NB = M / P;
  localparam int AW = acc_width(T, M);
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (M > 1) ? $clog2(M) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int MW = $clog2(N - M + 2);

  state_t state, state_nxt;
  logic [XW-1:0] x_cnt;
  logic [WW-1:0] w_cnt, w_idx;
  logic [MW-1:0] m_cnt;
  logic [BW-1:0] b_cnt;
  logic          w_loaded, issued;
  logic          w_take, x_take, adv, y_load, fin, last_beat, can_load;
  logic [T-1:0]  x_mem [N];
  logic [T-1:0]  w_mem [M];
  logic [P-1:0][T-1:0] x_lane, w_lane;
  logic signed [AW-1:0] acc_nxt;
  logic [T-1:0]  y_res;

  assign last_beat = (b_cnt == BW'(NB - 1));
  assign can_load  = !y_valid || y_ready;
  // A weight arriving in LOAD_X restarts the kernel at k=0.
  assign w_idx     = (state == LOAD_X) ? '0 : w_cnt;

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    w_ready   = 1'b0;
    w_take    = 1'b0;
    x_take    = 1'b0;
    adv       = 1'b0;
    y_load    = 1'b0;
    fin       = 1'b0;
    case (state)
      LOAD_W: begin
        w_ready = 1'b1;
        w_take  = w_valid;
        if (w_valid && w_cnt == WW'(M - 1)) state_nxt = LOAD_X;
      end
      LOAD_X: begin
        w_ready = (x_cnt == '0);
        x_ready = w_loaded && !(x_cnt == '0 && w_valid);
        w_take  = w_ready && w_valid;
        x_take  = x_ready && x_valid;
        if (w_take)                               state_nxt = (M == 1) ? LOAD_X : LOAD_W;
        else if (x_take && x_cnt == XW'(N - 1))   state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (issued) begin
          if (y_valid && y_ready) begin
            fin       = 1'b1;
            state_nxt = LOAD_X;
          end
        end else begin
          adv    = !last_beat || can_load;
          y_load = adv && last_beat;
        end
      end
      default: state_nxt = LOAD_W;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD_W;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_cnt    <= '0;
      x_cnt    <= '0;
      m_cnt    <= '0;
      b_cnt    <= '0;
      issued   <= 1'b0;
      w_loaded <= 1'b0;
      y_valid  <= 1'b0;
      y_data   <= '0;
    end else begin
      if (w_take) begin
        if (w_idx == WW'(M - 1)) begin
          w_cnt    <= '0;
          w_loaded <= 1'b1;
        end else begin
          w_cnt    <= w_idx + 1'b1;
          w_loaded <= 1'b0;
        end
      end
      if (x_take) x_cnt <= (x_cnt == XW'(N - 1)) ? '0 : x_cnt + 1'b1;
      if (adv) begin
        if (last_beat) begin
          b_cnt <= '0;
          if (m_cnt == MW'(N - M)) issued <= 1'b1;
          else                     m_cnt  <= m_cnt + 1'b1;
        end else begin
          b_cnt <= b_cnt + 1'b1;
        end
      end
      if (fin) begin
        issued <= 1'b0;
        m_cnt  <= '0;
      end
      if (y_load) begin
        y_valid <= 1'b1;
        y_data  <= y_res;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (x_take) x_mem[x_cnt] <= x_data;
    if (w_take) w_mem[w_idx] <= w_data;
  end

  always_comb begin
    for (int j = 0; j < P; j++) begin
      x_lane[j] = x_mem[XW'(int'(m_cnt) + int'(b_cnt) * P + j)];
      w_lane[j] = w_mem[WW'(int'(b_cnt) * P + j)];
    end
  end

  conv_mac_lanes #(.T(T), .P(P), .AW(AW)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (b_cnt == '0),
    .en      (adv),
    .x_lane  (x_lane),
    .w_lane  (w_lane),
    .acc_nxt (acc_nxt)
  );

  assign y_res = T'(sat_relu(SAT_W'(acc_nxt), FRAC, T, RELU != 0));

endmodule

// File: tb/tb_conv_1d_param.sv
// Scoreboard bench over three configurations: P=1, P=2, and N==M with FRAC=2/ReLU.
module tb_conv_1d_param;

  localparam int ND = 3;
  localparam int NP [ND] = '{32, 32, 4};
  localparam int MP [ND] = '{10, 10, 4};
  localparam int PP [ND] = '{1, 2, 2};
  localparam int FR [ND] = '{0, 0, 2};
  localparam int RL [ND] = '{0, 0, 1};

  typedef struct {
    int          d;
    logic [15:0] v;
  } exp_t;

  exp_t        sb[$];
  int          hsq[$];
  logic        clk;
  logic        rst     [ND];
  logic [15:0] x_data  [ND];
  logic [15:0] w_data  [ND];
  logic        x_valid [ND];
  logic        w_valid [ND];
  logic        y_ready [ND];
  wire         x_ready [ND];
  wire         w_ready [ND];
  wire         y_valid [ND];
  wire  [15:0] y_data  [ND];
  int          wv [ND][32];
  int          xv [ND][32];
  int          n_out  [ND];
  int          yr_mode[ND];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // y_ready: 0 = held high, 1 = random, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      y_ready[d] = (yr_mode[d] == 1) ? 1'($urandom_range(0, 1)) : (yr_mode[d] == 0);
  end

  for (genvar g = 0; g < ND; g++) begin : g_dut
    conv_1d_param #(.N(NP[g]), .M(MP[g]), .T(16), .P(PP[g]), .FRAC(FR[g]), .RELU(RL[g])) dut (
      .clk(clk), .reset(rst[g]),
      .x_data(x_data[g]), .x_valid(x_valid[g]), .x_ready(x_ready[g]),
      .w_data(w_data[g]), .w_valid(w_valid[g]), .w_ready(w_ready[g]),
      .y_data(y_data[g]), .y_valid(y_valid[g]), .y_ready(y_ready[g])
    );

    initial begin : mon
      logic        hold;
      logic [15:0] hold_v;
      exp_t        e;
      hold = 1'b0;
      forever begin
        @(negedge clk);
        if (rst[g] !== 1'b0) begin
          hold = 1'b0;
        end else begin
          if (hold) begin
            n_cmp++;
            if (y_valid[g] !== 1'b1 || y_data[g] !== hold_v) begin
              n_bad++;
              $display("FAIL hold_stable dut%0d: y_valid=%b y_data=%h, required 1 / %h", g, y_valid[g], y_data[g], hold_v);
            end
          end
          hold   = y_valid[g] && !y_ready[g];
          hold_v = y_data[g];
          if (y_valid[g] && y_ready[g]) begin
            n_out[g]++;
            hsq.push_back(cyc);
            n_cmp++;
            if (sb.size() == 0) begin
              n_bad++;
              $display("FAIL extra_output dut%0d: got %h, none expected", g, y_data[g]);
            end else begin
              e = sb.pop_front();
              if (e.d != g || y_data[g] !== e.v) begin
                n_bad++;
                $display("FAIL y_data dut%0d: got %h, required %h (queued for dut%0d)", g, y_data[g], e.v, e.d);
              end
            end
          end
        end
      end
    end
  end

  function automatic logic [15:0] golden(input int d, input int m);
    longint s = 0;
    for (int k = 0; k < MP[d]; k++) s += longint'(xv[d][m+k]) * longint'(wv[d][k]);
    s = s >>> FR[d];
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (RL[d] != 0 && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic push_exp(input int d, input logic [15:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic push_golden(input int d);
    for (int m = 0; m <= NP[d] - MP[d]; m++) push_exp(d, golden(d, m));
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic send_w(input int d, input bit rnd, input bit x_hi);
    int i = 0, guard = 0;
    bit acc;
    x_valid[d] = x_hi;
    x_data[d]  = 16'(xv[d][0]);
    while (i < MP[d] && guard < 4000) begin
      w_valid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_data[d]  = 16'(wv[d][i]);
      @(negedge clk);
      acc = w_valid[d] && w_ready[d];
      if (x_hi && i == 0 && acc) begin
        n_cmp++;
        if (x_ready[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL weights_win dut%0d: x_ready=%b, required 0", d, x_ready[d]);
        end
      end
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    w_valid[d] = 1'b0;
    x_valid[d] = 1'b0;
    n_cmp++;
    if (i != MP[d]) begin
      n_bad++;
      $display("FAIL w_load_timeout dut%0d: %0d weights accepted, required %0d", d, i, MP[d]);
    end
  endtask

  task automatic send_x(input int d, input bit rnd);
    int i = 0, guard = 0;
    bit acc;
    while (i < NP[d] && guard < 4000) begin
      x_valid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      x_data[d]  = 16'(xv[d][i]);
      @(negedge clk);
      acc = x_valid[d] && x_ready[d];
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    x_valid[d] = 1'b0;
    last_acc   = cyc;
    n_cmp++;
    if (i != NP[d]) begin
      n_bad++;
      $display("FAIL x_load_timeout dut%0d: %0d samples accepted, required %0d", d, i, NP[d]);
    end
  endtask

  task automatic drain(input int d, input int want, input int base);
    int t = 0;
    while (sb.size() != 0 && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout dut%0d: %0d outputs outstanding, required 0", d, sb.size());
    end
    n_cmp++;
    if (n_out[d] - base != want) begin
      n_bad++;
      $display("FAIL out_count dut%0d: got %0d outputs, required %0d", d, n_out[d] - base, want);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_cmp += 4;
      if (x_ready[d] !== 1'b0) begin n_bad++; $display("FAIL rst_x_ready dut%0d: %b, required 0", d, x_ready[d]); end
      if (w_ready[d] !== 1'b1) begin n_bad++; $display("FAIL rst_w_ready dut%0d: %b, required 1", d, w_ready[d]); end
      if (y_valid[d] !== 1'b0) begin n_bad++; $display("FAIL rst_y_valid dut%0d: %b, required 0", d, y_valid[d]); end
      if (y_data[d] !== 16'h0) begin n_bad++; $display("FAIL rst_y_data dut%0d: %h, required 0000", d, y_data[d]); end
    end
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base = n_out[0];
    for (int k = 0; k < 10; k++) wv[0][k] = 1;
    for (int i = 0; i < 32; i++) xv[0][i] = i;
    send_w(0, 0, 0);
    hsq.delete();
    send_x(0, 0);
    for (int m = 0; m < 23; m++) push_exp(0, 16'(10 * m + 45));
    drain(0, 23, base);
    n_cmp++;
    if (hsq.size() == 0 || hsq[0] - last_acc > 12) begin
      n_bad++;
      $display("FAIL first_latency: %0d cycles, required <= 12", (hsq.size() == 0) ? -1 : hsq[0] - last_acc);
    end
  endtask

  task automatic test_p2();
    int base;
    for (int k = 0; k < 10; k++) begin wv[0][k] = rnd16() >>> 4; wv[1][k] = wv[0][k]; end
    for (int i = 0; i < 32; i++) begin xv[0][i] = rnd16() >>> 4; xv[1][i] = xv[0][i]; end
    base = n_out[0];
    send_w(0, 0, 0);
    send_x(0, 0);
    push_golden(0);
    drain(0, 23, base);
    base = n_out[1];
    send_w(1, 0, 0);
    hsq.delete();
    send_x(1, 0);
    push_golden(1);
    drain(1, 23, base);
    for (int i = 1; i < hsq.size(); i++) begin
      n_cmp++;
      if (hsq[i] - hsq[i-1] != 5) begin
        n_bad++;
        $display("FAIL p2_spacing out%0d: %0d cycles, required 5", i, hsq[i] - hsq[i-1]);
      end
    end
  endtask

  task automatic test_saturation();
    int base = n_out[0];
    for (int k = 0; k < 10; k++) wv[0][k] = 32767;
    for (int i = 0; i < 32; i++) xv[0][i] = 32767;
    send_w(0, 0, 0);
    send_x(0, 0);
    for (int m = 0; m < 23; m++) push_exp(0, 16'h7FFF);
    drain(0, 23, base);
    base = n_out[0];
    for (int k = 0; k < 10; k++) wv[0][k] = -32768;
    send_w(0, 0, 0);
    send_x(0, 0);
    for (int m = 0; m < 23; m++) push_exp(0, 16'h8000);
    drain(0, 23, base);
    base = n_out[2];
    for (int k = 0; k < 4; k++) begin wv[2][k] = -32768; xv[2][k] = 32767; end
    send_w(2, 0, 0);
    send_x(2, 0);
    push_exp(2, 16'h0000);
    drain(2, 1, base);
    // 3-2+6+20 = 27, floor(27/4) = 6
    base = n_out[2];
    wv[2][0] = 3; wv[2][1] = -1; wv[2][2] = 2; wv[2][3] = 5;
    for (int k = 0; k < 4; k++) xv[2][k] = k + 1;
    send_w(2, 0, 0);
    send_x(2, 0);
    push_exp(2, 16'd6);
    drain(2, 1, base);
  endtask

  task automatic test_reload();
    int base = n_out[0];
    for (int k = 0; k < 10; k++) wv[0][k] = 1;
    for (int i = 0; i < 32; i++) xv[0][i] = i;
    send_w(0, 0, 0);
    send_x(0, 0);
    for (int m = 0; m < 23; m++) push_exp(0, 16'(10 * m + 45));
    for (int k = 0; k < 10; k++) wv[0][k] = 2;
    send_w(0, 0, 1);
    send_x(0, 0);
    for (int m = 0; m < 23; m++) push_exp(0, 16'(20 * m + 90));
    drain(0, 46, base);
  endtask

  task automatic test_random();
    int base = n_out[0];
    yr_mode[0] = 1;
    for (int v = 0; v < 100; v++) begin
      if (v % 25 == 0) begin
        for (int k = 0; k < 10; k++) wv[0][k] = rnd16();
        send_w(0, 1, 0);
      end
      for (int i = 0; i < 32; i++) xv[0][i] = (v % 2 == 0) ? rnd16() : (rnd16() >>> 6);
      send_x(0, 1);
      push_golden(0);
    end
    drain(0, 2300, base);
    yr_mode[0] = 0;
  endtask

  task automatic test_reset_mid();
    int base, t;
    for (int k = 0; k < 10; k++) wv[0][k] = rnd16() >>> 3;
    for (int i = 0; i < 32; i++) xv[0][i] = rnd16() >>> 3;
    send_w(0, 0, 0);
    base = n_out[0];
    send_x(0, 0);
    push_golden(0);
    t = 0;
    while (n_out[0] < base + 5 && t < 3000) begin @(posedge clk); #1; t++; end
    yr_mode[0] = 2;
    t = 0;
    while (y_valid[0] !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (n_out[0] - base != 5 || y_valid[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_setup: %0d outputs, y_valid=%b, required 5 / 1", n_out[0] - base, y_valid[0]);
    end
    #2;
    rst[0] = 1'b1;
    #1;
    n_cmp += 3;
    if (y_valid[0] !== 1'b0) begin n_bad++; $display("FAIL mid_rst_y_valid: %b, required 0", y_valid[0]); end
    if (y_data[0] !== 16'h0) begin n_bad++; $display("FAIL mid_rst_y_data: %h, required 0000", y_data[0]); end
    if (w_ready[0] !== 1'b1) begin n_bad++; $display("FAIL mid_rst_w_ready: %b, required 1", w_ready[0]); end
    sb.delete();
    @(posedge clk);
    #1;
    rst[0]     = 1'b0;
    yr_mode[0] = 0;
    for (int k = 0; k < 10; k++) wv[0][k] = rnd16() >>> 3;
    for (int i = 0; i < 32; i++) xv[0][i] = rnd16() >>> 3;
    send_w(0, 0, 0);
    base = n_out[0];
    send_x(0, 0);
    push_golden(0);
    drain(0, 23, base);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d]     = 1'b1;
      x_data[d]  = '0;
      w_data[d]  = '0;
      x_valid[d] = 1'b0;
      w_valid[d] = 1'b0;
      y_ready[d] = 1'b1;
      yr_mode[d] = 0;
      n_out[d]   = 0;
    end
    test_reset();
    test_basic();
    test_p2();
    test_saturation();
    test_reload();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
